// File: rtl/cook_stage_scheduler.sv
// Two-stage cook-program sequencer: per-stage time/power config, 1 Hz countdown,
// magnetron duty cycling over a DUTY_WIN-tick window, pause/resume and end-of-cook beep.
module cook_stage_scheduler #(
  parameter int SEC_W    = 10,
  parameter int DUTY_WIN = 10,
  parameter int BEEP_S   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             start,
  input  logic             stop,
  input  logic             door_closed,
  input  logic             cfg_we,
  input  logic             cfg_stage,
  input  logic [SEC_W-1:0] cfg_secs,
  input  logic [3:0]       cfg_power,
  output logic             mag_on,
  output logic             running,
  output logic             paused,
  output logic             cur_stage,
  output logic [SEC_W-1:0] secs_left,
  output logic             done_beep
);

  localparam int SLOT_W = (DUTY_WIN > 1) ? $clog2(DUTY_WIN) : 1;
  localparam int BEEP_W = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                   state, state_n;
  logic [1:0][SEC_W-1:0]    stage_secs, stage_secs_n;
  logic [1:0][3:0]          stage_pwr, stage_pwr_n;
  logic [SEC_W-1:0]         secs_n;
  logic [SLOT_W-1:0]        slot, slot_n;
  logic [BEEP_W-1:0]        beep_cnt, beep_n;
  logic                     stage_n;
  logic                     valid0, valid1;

  // Power is stored already clamped so every consumer sees the effective value.
  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return (p > 4'd10) ? 4'd10 : p;
  endfunction

  assign valid0 = (stage_pwr[0] != 4'd0) && (stage_secs[0] != '0);
  assign valid1 = (stage_pwr[1] != 4'd0) && (stage_secs[1] != '0);

  always_comb begin
    state_n      = state;
    stage_secs_n = stage_secs;
    stage_pwr_n  = stage_pwr;
    secs_n       = secs_left;
    slot_n       = slot;
    stage_n      = cur_stage;
    beep_n       = beep_cnt;
    case (state)
      IDLE: begin
        if (cfg_we) begin
          stage_secs_n[cfg_stage] = cfg_secs;
          stage_pwr_n[cfg_stage]  = clamp_power(cfg_power);
        end
        if (start && !stop && door_closed && (valid0 || valid1)) begin
          state_n = RUN;
          stage_n = ~valid0;
          secs_n  = valid0 ? stage_secs[0] : stage_secs[1];
          slot_n  = '0;
        end
      end
      RUN: begin
        if (tick_1hz) begin
          slot_n = (slot == SLOT_W'(DUTY_WIN - 1)) ? '0 : slot + SLOT_W'(1);
          if (secs_left == SEC_W'(1)) begin
            if (!cur_stage && valid1) begin
              stage_n = 1'b1;
              secs_n  = stage_secs[1];
              slot_n  = '0;
            end else begin
              state_n = DONE;
              secs_n  = '0;
              beep_n  = '0;
            end
          end else begin
            secs_n = secs_left - SEC_W'(1);
          end
        end
        // A finished cook goes to DONE even if a pause request lands on the final tick.
        if ((stop || !door_closed) && state_n == RUN) state_n = PAUSE;
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
          secs_n  = '0;
        end else if (start && door_closed) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tick_1hz) begin
          if (beep_cnt == BEEP_W'(BEEP_S - 1)) state_n = IDLE;
          else beep_n = beep_cnt + BEEP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      stage_secs <= '0;
      stage_pwr  <= '0;
      secs_left  <= '0;
      slot       <= '0;
      cur_stage  <= 1'b0;
      beep_cnt   <= '0;
    end else begin
      state      <= state_n;
      stage_secs <= stage_secs_n;
      stage_pwr  <= stage_pwr_n;
      secs_left  <= secs_n;
      slot       <= slot_n;
      cur_stage  <= stage_n;
      beep_cnt   <= beep_n;
    end
  end

  assign running   = (state == RUN);
  assign paused    = (state == PAUSE);
  assign done_beep = (state == DONE);
  // Door is a hard interlock: mag_on follows door_closed combinationally.
  assign mag_on    = running && door_closed && (int'(slot) < int'(stage_pwr[cur_stage]));

endmodule

// File: tb/tb_cook_stage_scheduler.sv
// Self-checking bench for cook_stage_scheduler: directed scenarios plus randomized
// cook programs checked against an elapsed-tick arithmetic model.
module tb_cook_stage_scheduler;

  localparam int SEC_W    = 10;
  localparam int DUTY_WIN = 10;
  localparam int BEEP_S   = 3;

  logic             clock = 1'b0;
  logic             reset, tick_1hz, start, stop, door_closed;
  logic             cfg_we, cfg_stage;
  logic [SEC_W-1:0] cfg_secs;
  logic [3:0]       cfg_power;
  logic             mag_on, running, paused, cur_stage, done_beep;
  logic [SEC_W-1:0] secs_left;

  int errors = 0;
  int checks = 0;

  cook_stage_scheduler #(.SEC_W(SEC_W), .DUTY_WIN(DUTY_WIN), .BEEP_S(BEEP_S)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .start(start), .stop(stop),
    .door_closed(door_closed), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
    .cfg_secs(cfg_secs), .cfg_power(cfg_power), .mag_on(mag_on), .running(running),
    .paused(paused), .cur_stage(cur_stage), .secs_left(secs_left), .done_beep(done_beep)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic write_cfg(input bit stg, input int secs, input int pwr);
    cfg_we    = 1'b1;
    cfg_stage = stg;
    cfg_secs  = SEC_W'(secs);
    cfg_power = 4'(pwr);
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mag_on, running, paused, cur_stage, done_beep, secs_left} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mag=%b run=%b pau=%b stg=%b beep=%b secs=%0d, want all 0",
               mag_on, running, paused, cur_stage, done_beep, secs_left);
    end
    pulse_start();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL reset_empty_start: running=%b want 0", running);
    end
  endtask

  // Model: after k ticks, the cook is in the first valid stage while k < a, else in
  // stage 1; the slot is the tick count within the stage modulo DUTY_WIN.
  task automatic test_cook(input string name, input int s0, input int p0,
                           input int s1, input int p1);
    int pe0, pe1, a, total, stg, left, slot, pe;
    bit v0, v1, exp_mag;
    do_reset();
    write_cfg(1'b0, s0, p0);
    write_cfg(1'b1, s1, p1);
    pe0 = (p0 > 10) ? 10 : p0;
    pe1 = (p1 > 10) ? 10 : p1;
    v0  = (pe0 != 0) && (s0 != 0);
    v1  = (pe1 != 0) && (s1 != 0);
    pulse_start();
    if (!v0 && !v1) begin
      checks++;
      if (running !== 1'b0) begin
        errors++;
        $display("FAIL %s_no_valid_start: running=%b want 0", name, running);
      end
      return;
    end
    a     = v0 ? s0 : s1;
    total = a + ((v0 && v1) ? s1 : 0);
    for (int k = 0; k < total; k++) begin
      if (k < a) begin
        stg  = v0 ? 0 : 1;
        left = a - k;
        slot = k % DUTY_WIN;
        pe   = v0 ? pe0 : pe1;
      end else begin
        stg  = 1;
        left = total - k;
        slot = (k - a) % DUTY_WIN;
        pe   = pe1;
      end
      exp_mag = (slot < pe);
      checks++;
      if (running !== 1'b1 || cur_stage !== stg[0]) begin
        errors++;
        $display("FAIL %s_state k=%0d: running=%b stage=%b want 1/%0d", name, k, running, cur_stage, stg);
      end
      checks++;
      if (secs_left !== SEC_W'(left) || mag_on !== exp_mag) begin
        errors++;
        $display("FAIL %s_count k=%0d: secs=%0d mag=%b want %0d/%b", name, k, secs_left, mag_on, left, exp_mag);
      end
      step(int'($urandom_range(2, 0)));
      do_tick();
    end
    checks++;
    if (done_beep !== 1'b1 || running !== 1'b0 || secs_left !== '0 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: beep=%b run=%b secs=%0d mag=%b want 1/0/0/0", name, done_beep, running, secs_left, mag_on);
    end
    for (int j = 1; j <= BEEP_S; j++) begin
      step(int'($urandom_range(1, 0)));
      do_tick();
      checks++;
      if (done_beep !== (j < BEEP_S)) begin
        errors++;
        $display("FAIL %s_beep tick=%0d: beep=%b want %b", name, j, done_beep, (j < BEEP_S));
      end
    end
    checks++;
    if (running !== 1'b0 || paused !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: running=%b paused=%b want 0/0", name, running, paused);
    end
  endtask

  task automatic test_door_pause();
    do_reset();
    write_cfg(1'b0, 8, 10);
    pulse_start();
    repeat (3) do_tick();
    checks++;
    if (mag_on !== 1'b1 || secs_left !== SEC_W'(5)) begin
      errors++;
      $display("FAIL door_pre: mag=%b secs=%0d want 1/5", mag_on, secs_left);
    end
    door_closed = 1'b0;
    #1;
    checks++;
    if (mag_on !== 1'b0) begin
      errors++;
      $display("FAIL door_mag_same_cycle: mag=%b want 0", mag_on);
    end
    step();
    checks++;
    if (paused !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL door_paused: paused=%b running=%b want 1/0", paused, running);
    end
    start = 1'b1;
    step(2);
    start = 1'b0;
    do_tick();
    checks++;
    if (paused !== 1'b1 || secs_left !== SEC_W'(5)) begin
      errors++;
      $display("FAIL door_open_start: paused=%b secs=%0d want 1/5", paused, secs_left);
    end
    door_closed = 1'b1;
    pulse_start();
    checks++;
    if (running !== 1'b1 || secs_left !== SEC_W'(5) || mag_on !== 1'b1) begin
      errors++;
      $display("FAIL door_resume: running=%b secs=%0d mag=%b want 1/5/1", running, secs_left, mag_on);
    end
    repeat (5) do_tick();
    checks++;
    if (done_beep !== 1'b1) begin
      errors++;
      $display("FAIL door_finish: beep=%b want 1", done_beep);
    end
  endtask

  task automatic test_start_stop();
    do_reset();
    write_cfg(1'b0, 5, 10);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (running !== 1'b0 || paused !== 1'b0) begin
      errors++;
      $display("FAIL startstop_idle: running=%b paused=%b want 0/0", running, paused);
    end
    pulse_start();
    start = 1'b1; stop = 1'b1; tick_1hz = 1'b1;
    step();
    start = 1'b0; stop = 1'b0; tick_1hz = 1'b0;
    checks++;
    if (paused !== 1'b1 || secs_left !== SEC_W'(4)) begin
      errors++;
      $display("FAIL startstop_run: paused=%b secs=%0d want 1/4", paused, secs_left);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (paused !== 1'b0 || running !== 1'b0 || secs_left !== '0) begin
      errors++;
      $display("FAIL stop_in_pause: paused=%b running=%b secs=%0d want 0/0/0", paused, running, secs_left);
    end
    pulse_start();
    write_cfg(1'b0, 9, 1);
    stop = 1'b1;
    step(2);
    stop = 1'b0;
    pulse_start();
    do_tick();
    checks++;
    if (running !== 1'b1 || secs_left !== SEC_W'(4) || mag_on !== 1'b1) begin
      errors++;
      $display("FAIL cfg_in_run: running=%b secs=%0d mag=%b want 1/4/1", running, secs_left, mag_on);
    end
    repeat (4) do_tick();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (done_beep !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL stop_in_done: beep=%b running=%b want 0/0", done_beep, running);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_cfg(1'b0, 10, 10);
    pulse_start();
    repeat (3) do_tick();
    checks++;
    if (secs_left !== SEC_W'(7) || mag_on !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: secs=%0d mag=%b want 7/1", secs_left, mag_on);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({mag_on, running, paused, cur_stage, done_beep, secs_left} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: mag=%b run=%b pau=%b stg=%b beep=%b secs=%0d want all 0",
               mag_on, running, paused, cur_stage, done_beep, secs_left);
    end
    pulse_start();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cfg_lost: running=%b want 0", running);
    end
  endtask

  initial begin
    reset = 1'b0; tick_1hz = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
    cfg_we = 1'b0; cfg_stage = 1'b0; cfg_secs = '0; cfg_power = '0;
    test_reset();
    test_cook("single_p10", 5, 10, 0, 0);
    test_cook("duty_p3", 20, 3, 0, 0);
    test_cook("two_stage", 2, 10, 3, 5);
    test_cook("s1_only", 0, 0, 4, 7);
    test_cook("s0_zero_pwr", 3, 0, 4, 7);
    test_cook("clamp", 12, 15, 11, 13);
    test_cook("none_valid", 5, 0, 0, 6);
    for (int i = 0; i < 8; i++) begin
      test_cook("random", int'($urandom_range(14, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(14, 0)), int'($urandom_range(15, 0)));
    end
    test_door_pause();
    test_start_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
